// File: rtl/waveform_player_pkg.sv
// waveform_player_pkg: shared constants and types for the waveform player.
//   - SPI master register offsets (relative to the SPI base address)
//   - SPI STATUS register bit positions
//   - playback FSM state encoding
package waveform_player_pkg;

  localparam logic [31:0] SPI_ARM_OFF      = 32'h4;
  localparam logic [31:0] SPI_TO_SLAVE_OFF = 32'hC;
  localparam logic [31:0] SPI_STATUS_OFF   = 32'h10;

  localparam int unsigned READY_TO_ARM = 0;
  localparam int unsigned FINISHED     = 1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StArm,
    StPoll,
    StDisarm,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/waveform_player_if.sv
// waveform_player_if: Wishbone classic bus between the waveform player (master)
// and the RAM / SPI-master address space (slave).
//   wb_adr, wb_cyc, wb_stb, wb_we, wb_dat_w, wb_sel : master -> slave
//   wb_dat_r, wb_ack                                 : slave -> master
interface waveform_player_if;

  logic [31:0] wb_adr;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic [3:0]  wb_sel;

  modport master (
    output wb_adr, wb_cyc, wb_stb, wb_we, wb_dat_w, wb_sel,
    input  wb_dat_r, wb_ack
  );

  modport slave (
    input  wb_adr, wb_cyc, wb_stb, wb_we, wb_dat_w, wb_sel,
    output wb_dat_r, wb_ack
  );

endinterface

// File: rtl/waveform_wb_xfer.sv
// waveform_wb_xfer: single-transaction Wishbone classic master.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          request a transaction (taken when ready=1)
//   adr, we, dat_w transaction attributes, captured when start is taken
//   ready          no cycle open and slave ack low
//   done           one-cycle pulse the cycle after the ack
//   dat_r          read data captured on the ack cycle
//   wb             Wishbone master port
// cyc/stb are held with stable attributes until ack, drop on the following cycle,
// and a new cycle waits for ack to fall since the slave keeps ack high until it
// sees cyc low.
module waveform_wb_xfer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] adr,
  input  logic        we,
  input  logic [31:0] dat_w,
  output logic        ready,
  output logic        done,
  output logic [31:0] dat_r,
  waveform_player_if.master wb
);

  logic        cyc_q;
  logic        we_q;
  logic        done_q;
  logic [31:0] adr_q;
  logic [31:0] dat_w_q;
  logic [31:0] dat_r_q;

  assign ready = ~cyc_q & ~wb.wb_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      adr_q   <= '0;
      dat_w_q <= '0;
      dat_r_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (cyc_q) begin
        if (wb.wb_ack) begin
          cyc_q   <= 1'b0;
          dat_r_q <= wb.wb_dat_r;
          done_q  <= 1'b1;
        end
      end else if (start && !wb.wb_ack) begin
        cyc_q   <= 1'b1;
        adr_q   <= adr;
        we_q    <= we;
        dat_w_q <= dat_w;
      end
    end
  end

  assign done        = done_q;
  assign dat_r       = dat_r_q;
  assign wb.wb_cyc   = cyc_q;
  assign wb.wb_stb   = cyc_q;
  assign wb.wb_we    = we_q;
  assign wb.wb_adr   = adr_q;
  assign wb.wb_dat_w = dat_w_q;
  assign wb.wb_sel   = 4'b1111;

endmodule

// File: rtl/waveform_player.sv
// waveform_player: bus-mastering waveform generator. Reads 32-bit samples from
// RAM over Wishbone, writes each to an SPI master (TO_SLAVE, ARM, poll STATUS,
// DISARM), then waits timer_spacing cycles before the next sample.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   run              start playback from idle (level)
//   force_stop       abort playback at the next transaction boundary
//   do_loop          wrap to sample 0 after the last sample
//   wform_size       number of samples
//   timer_spacing    extra delay cycles between samples
//   cntr             index of the current sample
//   timer            current inter-sample delay count
//   finished         non-looping playback complete
//   ready            idle, accepting run
//   wb               Wishbone master port
// Build option: define WAVEFORM_DAC_CMD_EN to wrap each sample into an AD5791
// DAC-register write command; otherwise the RAM word is sent verbatim.
module waveform_player
  import waveform_player_pkg::*;
#(
  parameter logic [31:0] RAM_START_ADDR  = 32'h0,
  parameter logic [31:0] SPI_START_ADDR  = 32'h1000_0000,
  parameter int unsigned COUNTER_MAX_WID = 16,
  parameter int unsigned TIMER_WID       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       force_stop,
  input  logic                       do_loop,
  input  logic [COUNTER_MAX_WID-1:0] wform_size,
  input  logic [TIMER_WID-1:0]       timer_spacing,
  output logic [COUNTER_MAX_WID-1:0] cntr,
  output logic [TIMER_WID-1:0]       timer,
  output logic                       finished,
  output logic                       ready,
  waveform_player_if.master          wb
);

  state_e                     state_q, state_d;
  logic [COUNTER_MAX_WID-1:0] cntr_q, cntr_d;
  logic [TIMER_WID-1:0]       timer_q, timer_d;
  logic [31:0]                sample_q, sample_d;
  logic                       pend_q, pend_d;  // a transaction for this state is in flight
  logic                       stop_q, stop_d;  // force_stop seen, waiting for a boundary

  logic        stop_now;
  logic        bus_state;
  logic        last;
  logic        xfer_start;
  logic [31:0] xfer_adr;
  logic        xfer_we;
  logic [31:0] xfer_dat;
  logic        xfer_ready;
  logic        xfer_done;
  logic [31:0] xfer_rdata;
  logic [31:0] tx_data;

`ifdef WAVEFORM_DAC_CMD_EN
  assign tx_data = {8'h00, 4'b0001, sample_q[19:0]};
`else
  assign tx_data = sample_q;
`endif

  waveform_wb_xfer u_xfer (
    .clk   (clk),
    .rst   (rst),
    .start (xfer_start),
    .adr   (xfer_adr),
    .we    (xfer_we),
    .dat_w (xfer_dat),
    .ready (xfer_ready),
    .done  (xfer_done),
    .dat_r (xfer_rdata),
    .wb    (wb)
  );

  assign stop_now  = stop_q | force_stop;
  assign bus_state = (state_q == StRead) || (state_q == StLoad) || (state_q == StArm) ||
                     (state_q == StPoll) || (state_q == StDisarm);
  assign last      = (cntr_q == wform_size - COUNTER_MAX_WID'(1));

  always_comb begin
    xfer_adr = '0;
    xfer_we  = 1'b0;
    xfer_dat = '0;
    case (state_q)
      StRead:   xfer_adr = RAM_START_ADDR + (32'(cntr_q) << 2);
      StLoad:   begin
        xfer_adr = SPI_START_ADDR + SPI_TO_SLAVE_OFF;
        xfer_we  = 1'b1;
        xfer_dat = tx_data;
      end
      StArm:    begin
        xfer_adr = SPI_START_ADDR + SPI_ARM_OFF;
        xfer_we  = 1'b1;
        xfer_dat = 32'd1;
      end
      StPoll:   xfer_adr = SPI_START_ADDR + SPI_STATUS_OFF;
      StDisarm: begin
        xfer_adr = SPI_START_ADDR + SPI_ARM_OFF;
        xfer_we  = 1'b1;
      end
      default:  ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cntr_d     = cntr_q;
    timer_d    = timer_q;
    sample_d   = sample_q;
    pend_d     = pend_q;
    stop_d     = (state_q == StIdle) ? 1'b0 : stop_now;
    xfer_start = 1'b0;

    if (bus_state) begin
      if (pend_q) begin
        if (xfer_done) begin
          pend_d = 1'b0;
          case (state_q)
            StRead:   begin
              sample_d = xfer_rdata;
              state_d  = stop_now ? StIdle : StLoad;
            end
            StLoad:   state_d = stop_now ? StIdle : StArm;
            // Once ARM has landed the SPI master must be disarmed even when stopping.
            StArm:    state_d = stop_now ? StDisarm : StPoll;
            StPoll:   state_d = (stop_now || xfer_rdata[FINISHED]) ? StDisarm : StPoll;
            StDisarm: begin
              state_d = stop_now ? StIdle : StWait;
              timer_d = '0;
            end
            default:  ;
          endcase
        end
      end else if (stop_now && state_q != StDisarm) begin
        // Boundary with nothing in flight: skip the pending transaction.
        state_d = (state_q == StPoll) ? StDisarm : StIdle;
      end else begin
        xfer_start = 1'b1;
        if (xfer_ready) pend_d = 1'b1;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (!force_stop && run) begin
            cntr_d  = '0;
            state_d = (wform_size != '0) ? StRead : StDone;
          end
        end
        StWait: begin
          if (stop_now) begin
            state_d = StIdle;
          end else if (timer_q == timer_spacing) begin
            state_d = StRead;
            if (last) begin
              if (do_loop) cntr_d = '0;
              else         state_d = StDone;
            end else begin
              cntr_d = cntr_q + COUNTER_MAX_WID'(1);
            end
          end else begin
            timer_d = timer_q + TIMER_WID'(1);
          end
        end
        StDone: begin
          if (stop_now || !run) state_d = StIdle;
        end
        default: ;
      endcase
    end

    if (state_d == StIdle && state_q != StIdle) begin
      cntr_d  = '0;
      timer_d = '0;
      stop_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cntr_q   <= '0;
      timer_q  <= '0;
      sample_q <= '0;
      pend_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cntr_q   <= cntr_d;
      timer_q  <= timer_d;
      sample_q <= sample_d;
      pend_q   <= pend_d;
      stop_q   <= stop_d;
    end
  end

  assign cntr     = cntr_q;
  assign timer    = timer_q;
  assign finished = (state_q == StDone);
  assign ready    = (state_q == StIdle);

endmodule

// File: tb/tb_waveform_player.sv
// tb_waveform_player: self-checking bench for waveform_player. A Wishbone slave
// model serves sample RAM and an SPI master (status stall, finished on the
// second poll after ARM). Expected bus transactions are queued per sample and
// compared as the slave acknowledges them.
module tb_waveform_player;
  import waveform_player_pkg::*;

  localparam logic [31:0] SPI = 32'h1000_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        run;
  logic        force_stop;
  logic        do_loop;
  logic [15:0] wform_size;
  logic [15:0] timer_spacing;
  logic [15:0] cntr;
  logic [15:0] timer;
  logic        finished;
  logic        ready;

  waveform_player_if wb ();

  waveform_player dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .force_stop    (force_stop),
    .do_loop       (do_loop),
    .wform_size    (wform_size),
    .timer_spacing (timer_spacing),
    .cntr          (cntr),
    .timer         (timer),
    .finished      (finished),
    .ready         (ready),
    .wb            (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  int   extra_cnt = 0;
  txn_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] ram [16];
  int spi_stall;
  int stall_cnt;
  int poll_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.wb_ack   <= 1'b0;
      wb.wb_dat_r <= '0;
      stall_cnt   <= 0;
      poll_cnt    <= 0;
    end else if (wb.wb_ack) begin
      if (!wb.wb_cyc) wb.wb_ack <= 1'b0;
    end else if (wb.wb_cyc && wb.wb_stb) begin
      if (!wb.wb_we && wb.wb_adr == SPI + SPI_STATUS_OFF && stall_cnt < spi_stall) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        wb.wb_ack <= 1'b1;
        stall_cnt <= 0;
        if (wb.wb_we) begin
          if (wb.wb_adr == SPI + SPI_ARM_OFF && wb.wb_dat_w == 32'd1) poll_cnt <= 0;
        end else if (wb.wb_adr == SPI + SPI_STATUS_OFF) begin
          wb.wb_dat_r <= {30'd0, poll_cnt > 0, 1'b1};
          poll_cnt    <= poll_cnt + 1;
        end else begin
          wb.wb_dat_r <= ram[wb.wb_adr[5:2]];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  function automatic logic [31:0] exp_tx(input logic [31:0] v);
`ifdef WAVEFORM_DAC_CMD_EN
    return {8'h00, 4'b0001, v[19:0]};
`else
    return v;
`endif
  endfunction

  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    txn_t t;
    t.we  = we;
    t.adr = adr;
    t.dat = dat;
    sb_q.push_back(t);
  endtask

  task automatic push_sample(input int idx);
    push(1'b0, 32'(idx) * 4, 32'd0);
    push(1'b1, SPI + SPI_TO_SLAVE_OFF, exp_tx(ram[idx]));
    push(1'b1, SPI + SPI_ARM_OFF, 32'd1);
    push(1'b0, SPI + SPI_STATUS_OFF, 32'd0);
    push(1'b0, SPI + SPI_STATUS_OFF, 32'd0);
    push(1'b1, SPI + SPI_ARM_OFF, 32'd0);
  endtask

  // ---------------- bus monitor ----------------
  logic prev_cyc;
  logic prev_ackcyc;
  logic tact;
  logic fin_seen;
  int   texp;

  initial begin
    txn_t e;
    prev_cyc    = 1'b0;
    prev_ackcyc = 1'b0;
    tact        = 1'b0;
    fin_seen    = 1'b0;
    texp        = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cyc    = 1'b0;
        prev_ackcyc = 1'b0;
        tact        = 1'b0;
      end else begin
        if (wb.wb_cyc) begin
          chk("stb_with_cyc", wb.wb_stb, 1);
          chk("sel", wb.wb_sel, 4'hF);
        end
        if (wb.wb_cyc && !prev_cyc) chk("ack_low_at_start", wb.wb_ack, 0);
        if (prev_ackcyc) chk("cyc_drop_after_ack", wb.wb_cyc, 0);
        if (ready) tact = 1'b0;
        // After DISARM the timer must step through 0..timer_spacing in order.
        if (tact) begin
          if ((wb.wb_cyc && !prev_cyc) || finished) begin
            chk("wait_timer_span", texp, 32'(timer_spacing) + 1);
            tact = 1'b0;
          end else if (32'(timer) == texp) begin
            texp++;
          end
        end
        if (wb.wb_cyc && wb.wb_ack) begin
          if (sb_q.size() == 0) begin
            extra_cnt++;
          end else begin
            e = sb_q.pop_front();
            chk("bus_adr", wb.wb_adr, e.adr);
            chk("bus_we", wb.wb_we, e.we);
            if (e.we) chk("bus_wdat", wb.wb_dat_w, e.dat);
          end
          if (wb.wb_we && wb.wb_adr == SPI + SPI_ARM_OFF && wb.wb_dat_w == 32'd0) begin
            tact = 1'b1;
            texp = 0;
          end
        end
        fin_seen    = fin_seen | finished;
        prev_cyc    = wb.wb_cyc;
        prev_ackcyc = wb.wb_cyc & wb.wb_ack;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_fin(input int max);
    for (int i = 0; i < max && !finished; i++) @(negedge clk);
    if (!finished) chk("finish_timeout", finished, 1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'hA5A5_0000 + 32'(i);
    ram[0] = 32'h11;
    ram[1] = 32'h22;
    ram[2] = 32'h33;
    spi_stall     = 2;
    rst           = 1'b1;
    run           = 1'b0;
    force_stop    = 1'b0;
    do_loop       = 1'b0;
    wform_size    = '0;
    timer_spacing = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_finished", finished, 0);
    chk("rst_cntr", cntr, 0);
    chk("rst_timer", timer, 0);
    chk("rst_cyc", wb.wb_cyc, 0);
    chk("rst_we", wb.wb_we, 0);
    chk("rst_adr", wb.wb_adr, 0);
    chk("rst_dat_w", wb.wb_dat_w, 0);
    rst = 1'b0;

    // Three samples, no loop, spacing 2.
    wform_size    = 16'd3;
    timer_spacing = 16'd2;
    do_loop       = 1'b0;
    for (int i = 0; i < 3; i++) push_sample(i);
    @(negedge clk);
    run = 1'b1;
    wait_fin(3000);
    chk("t1_finished", finished, 1);
    chk("t1_ready_in_done", ready, 0);
    chk("t1_cntr_in_done", cntr, 2);
    chk("t1_sb_left", sb_q.size(), 0);
    run = 1'b0;
    @(negedge clk);
    chk("t1_ready_after", ready, 1);
    chk("t1_cntr_after", cntr, 0);
    chk("t1_finished_after", finished, 0);

    // Looping over two samples; run is only pulsed.
    wform_size    = 16'd2;
    do_loop       = 1'b1;
    timer_spacing = 16'd0;
    fin_seen      = 1'b0;
    extra_cnt     = 0;
    push_sample(0);
    push_sample(1);
    push_sample(0);
    push_sample(1);
    push_sample(0);
    run = 1'b1;
    repeat (3) @(negedge clk);
    run = 1'b0;
    wait_drain(3000);
    force_stop = 1'b1;
    repeat (2) @(negedge clk);
    force_stop = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_finished_never", fin_seen, 0);
    chk("t2_extra_txn", extra_cnt, 0);
    chk("t2_ready", ready, 1);
    chk("t2_cntr", cntr, 0);

    // Long status stall.
    spi_stall     = 50;
    wform_size    = 16'd1;
    do_loop       = 1'b0;
    timer_spacing = 16'd1;
    push_sample(0);
    run = 1'b1;
    wait_fin(3000);
    chk("t3_finished", finished, 1);
    chk("t3_sb_left", sb_q.size(), 0);
    run = 1'b0;
    @(negedge clk);
    chk("t3_ready", ready, 1);

    // force_stop during the wait after sample 1.
    spi_stall     = 2;
    wform_size    = 16'd4;
    do_loop       = 1'b1;
    timer_spacing = 16'd20;
    extra_cnt     = 0;
    push_sample(0);
    push_sample(1);
    run = 1'b1;
    repeat (2) @(negedge clk);
    run = 1'b0;
    wait_drain(3000);
    repeat (5) @(negedge clk);
    chk("t4_cntr_in_wait", cntr, 1);
    force_stop = 1'b1;
    @(negedge clk);
    force_stop = 1'b0;
    @(negedge clk);
    chk("t4_ready", ready, 1);
    chk("t4_cntr", cntr, 0);
    chk("t4_timer", timer, 0);
    chk("t4_finished", finished, 0);
    repeat (30) @(negedge clk);
    chk("t4_extra_txn", extra_cnt, 0);

    // force_stop wins over a simultaneous run.
    wform_size = 16'd3;
    run        = 1'b1;
    force_stop = 1'b1;
    @(negedge clk);
    chk("t5_ready", ready, 1);
    chk("t5_cyc", wb.wb_cyc, 0);
    run        = 1'b0;
    force_stop = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_extra_txn", extra_cnt, 0);

    // Empty waveform.
    wform_size = 16'd0;
    run        = 1'b1;
    @(negedge clk);
    chk("t6_finished", finished, 1);
    chk("t6_ready", ready, 0);
    repeat (5) @(negedge clk);
    chk("t6_extra_txn", extra_cnt, 0);
    run = 1'b0;
    @(negedge clk);
    chk("t6_ready_after", ready, 1);
    chk("t6_finished_after", finished, 0);

    // Reset in the middle of the TO_SLAVE write.
    wform_size    = 16'd3;
    timer_spacing = 16'd2;
    do_loop       = 1'b0;
    push_sample(0);
    run = 1'b1;
    for (int i = 0; i < 500 && !(wb.wb_cyc && wb.wb_we); i++) @(negedge clk);
    chk("t7_write_open", wb.wb_cyc & wb.wb_we, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t7_cyc", wb.wb_cyc, 0);
    chk("t7_stb", wb.wb_stb, 0);
    chk("t7_we", wb.wb_we, 0);
    chk("t7_adr", wb.wb_adr, 0);
    chk("t7_dat_w", wb.wb_dat_w, 0);
    chk("t7_cntr", cntr, 0);
    chk("t7_timer", timer, 0);
    chk("t7_finished", finished, 0);
    chk("t7_ready", ready, 1);
    sb_q.delete();
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_ready_after", ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/waveform_player.md
Name: waveform_player

Overview:
- Bus-mastering waveform generator. Reads successive 32-bit samples from RAM over Wishbone and pushes each one to a memory-mapped SPI master, which drives the DAC.
- Paces samples with a programmable inter-sample delay, with optional looping.
- Sits between the waveform sample RAM and the DAC SPI master. Control and status come from CSRs.

Parameters:
- RAM_START_ADDR, 32'h0: byte address of sample 0. Sample n is at RAM_START_ADDR + 4*n.
- SPI_START_ADDR, 32'h10000000: SPI master base. Register offsets: ARM +0x4, TO_SLAVE +0xC, STATUS +0x10.
- COUNTER_MAX_WID, 16: width of the sample counter and waveform size.
- TIMER_WID, 16: width of the spacing timer.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  start playback (level)
- force_stop  in  1  abort playback
- cntr  out  COUNTER_MAX_WID  index of the current sample
- do_loop  in  1  wrap to sample 0 after the last sample
- finished  out  1  non-looping playback complete
- ready  out  1  idle, accepting run
- wform_size  in  COUNTER_MAX_WID  number of samples
- timer  out  TIMER_WID  current inter-sample delay count
- timer_spacing  in  TIMER_WID  delay cycles between samples
- wb_adr  out  32  Wishbone byte address
- wb_cyc, wb_stb, wb_we  out  1  Wishbone classic master controls
- wb_dat_w  out  32  write data
- wb_dat_r  in  32  read data
- wb_ack  in  1  slave acknowledge
- wb_sel  out  4  byte selects, constant 4'b1111

Behaviour:
- Reset values: cntr=0, timer=0, finished=0, ready=1, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, state IDLE.
- Bus transaction rules:
  - Assert cyc and stb together, with adr/we/dat_w stable, and hold them until ack=1.
  - Capture wb_dat_r on the ack cycle.
  - Deassert cyc and stb in the cycle following ack.
  - Start the next transaction only once ack is low, because the slave holds ack until cyc drops.
  - Exactly one transaction is outstanding at a time.
- States:
  - IDLE: ready=1. When run=1 and wform_size!=0, go to READ with cntr=0. When run=1 and wform_size==0, go to DONE.
  - READ: read RAM_START_ADDR+(cntr<<2) and latch the sample.
  - LOAD: write the sample to SPI+0xC.
  - ARM: write 1 to SPI+0x4.
  - POLL: read SPI+0x10. The slave may stall ack until ready_to_arm or finished. If bit1 (finished)=1, go to DISARM; otherwise repeat POLL.
  - DISARM: write 0 to SPI+0x4, then go to WAIT with timer=0.
  - WAIT: increment timer each cycle until timer==timer_spacing. Then:
    - if cntr==wform_size-1 and do_loop=1: cntr=0, go to READ;
    - if cntr==wform_size-1 and do_loop=0: go to DONE;
    - otherwise cntr+1, go to READ.
  - DONE: finished=1, ready=0. When run=0: finished=0, cntr=0, go to IDLE.
- Width and timing rules:
  - timer_spacing=0 gives zero extra delay; WAIT lasts one cycle.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
- do_loop and timer_spacing are sampled at each WAIT exit. wform_size is sampled at each comparison.
- force_stop:
  - Takes effect at the next transaction boundary. A cycle in flight completes; cyc is never dropped before ack.
  - If ARM has completed, DISARM is issued first.
  - Then go to IDLE with cntr=0, timer=0, finished=0.
  - force_stop overrides a simultaneous run.
- Reset mid-transaction: cyc/stb drop immediately and all state returns to reset values.
- run deasserted mid-playback does not stop playback; only force_stop does.

Optional Feature:
- Macro WAVEFORM_DAC_CMD_EN.
  - Defined: the TO_SLAVE write data is {8'h00, 4'b0001, sample[19:0]}, i.e. an AD5791 DAC-register write command.
  - Undefined: the RAM word is written verbatim.

Decomposition:
- Package waveform_player_pkg:
  - register offsets SPI_ARM_OFF=32'h4, SPI_TO_SLAVE_OFF=32'hC, SPI_STATUS_OFF=32'h10;
  - STATUS bit indices READY_TO_ARM=0, FINISHED=1;
  - the state enum.
- Sub-module waveform_wb_xfer: single-transaction Wishbone master. Takes start/adr/we/dat in and returns done/dat, enforcing the ack/cyc rules above.

Test Plan:
- wform_size=3, timer_spacing=2, do_loop=0, RAM={0x11,0x22,0x33}, run=1:
  - TO_SLAVE writes 0x11, 0x22, 0x33 in order;
  - each is followed by ARM=1, POLL, ARM=0;
  - each WAIT sees timer count 0..2;
  - finished=1 after the third sample;
  - run=0 then gives ready=1, cntr=0.
- wform_size=2, do_loop=1: RAM addresses read are 0x0, 0x4, 0x0, 0x4, ... and finished stays 0.
- SPI status stalls ack for 50 cycles (spi_max_wait=50): no ARM=0 write before bit1=1; no overlapping transactions; cyc drops one cycle after each ack.
- force_stop asserted during WAIT of sample 1 with do_loop=1: no further TO_SLAVE writes; ready=1, cntr=0, finished=0.
- wform_size=0, run=1: no bus traffic; finished=1 next cycle.
- Reset asserted while cyc=1: cyc/stb=0 asynchronously; all outputs at reset values.
